// File: rtl/usb_frame_parser.sv
// -----------------------------------------------------------------------------
// usb_frame_parser
//   Receive-side command parser behind the USB EP2 read path. It takes the
//   16-bit words drained from the FX2 FIFO and decodes framed load commands:
//     H {A5, 000000, target} | A start address | L length N | N payload | C sum
//   Each payload is written into the image (0), weight (1) or bias (2) memory.
//   At the end of every frame it presents one status word for the EP6 path.
//
// Ports
//   i_usb_ifclk     sole clock (USB interface clock)
//   i_rst           asynchronous active-high reset
//   i_rx_valid      i_rx_data holds a received word
//   i_rx_data       received word
//   o_rx_ready      word accepted when i_rx_valid && o_rx_ready
//   o_mem_we        registered write strobe, one cycle per payload word
//   o_mem_sel       target memory of the write
//   o_mem_addr      write address
//   o_mem_wdata     write data
//   o_status_valid  status word pending
//   o_status        {ok, code[2:0], target[1:0], words_written[9:0]}
//   i_status_ready  TX path accepts the status word
//
// States
//   S_HDR    | waiting for the header word H
//   S_ADDR   | waiting for the start address A
//   S_LEN    | waiting for the payload length L
//   S_PAY    | consuming payload words, writing them to memory
//   S_CSUM   | waiting for the checksum word C
//   S_REPORT | status presented, waiting for the TX handshake
// -----------------------------------------------------------------------------
module usb_frame_parser #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_usb_ifclk,
  input  logic                  i_rst,
  input  logic                  i_rx_valid,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  output logic                  o_rx_ready,
  output logic                  o_mem_we,
  output logic [1:0]            o_mem_sel,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_status_valid,
  output logic [15:0]           o_status,
  input  logic                  i_status_ready
);

  typedef enum logic [2:0] {
    S_HDR    = 3'd0,
    S_ADDR   = 3'd1,
    S_LEN    = 3'd2,
    S_PAY    = 3'd3,
    S_CSUM   = 3'd4,
    S_REPORT = 3'd5
  } state_t;

  localparam logic [7:0] MAGIC = 8'hA5;

  // Range check of base + N is done wide enough that it can never wrap.
  localparam int EW = ADDR_WIDTH + 17;
  localparam logic [EW-1:0] MEM_DEPTH = EW'(1) << ADDR_WIDTH;

  localparam logic [2:0] CODE_OK    = 3'd0;
  localparam logic [2:0] CODE_MAGIC = 3'd1;
  localparam logic [2:0] CODE_TGT   = 3'd2;
  localparam logic [2:0] CODE_LEN0  = 3'd3;
  localparam logic [2:0] CODE_RANGE = 3'd4;
  localparam logic [2:0] CODE_CSUM  = 3'd5;

  state_t                  state_q, state_d;
  logic [1:0]              target_q, target_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;     // address of the next payload word
  logic [15:0]             remain_q, remain_d;
  logic [15:0]             sum_q, sum_d;
  logic                    range_q, range_d;
  logic [9:0]              written_q, written_d;
  logic [15:0]             status_q, status_d;
  logic                    mem_we_q, mem_we_d;
  logic [1:0]              mem_sel_q, mem_sel_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

  logic                    accept;
  logic [EW-1:0]           end_ext;

  assign o_rx_ready     = (state_q != S_REPORT);
  assign o_status_valid = (state_q == S_REPORT);
  assign o_status       = status_q;
  assign o_mem_we       = mem_we_q;
  assign o_mem_sel      = mem_sel_q;
  assign o_mem_addr     = mem_addr_q;
  assign o_mem_wdata    = mem_wdata_q;

  assign accept  = i_rx_valid && o_rx_ready;
  assign end_ext = EW'(waddr_q) + EW'(i_rx_data);

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    waddr_d     = waddr_q;
    remain_d    = remain_q;
    sum_d       = sum_q;
    range_d     = range_q;
    written_d   = written_q;
    status_d    = status_q;
    mem_we_d    = 1'b0;
    mem_sel_d   = mem_sel_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_HDR: begin
        if (accept) begin
          sum_d     = '0;
          range_d   = 1'b0;
          written_d = '0;
          remain_d  = '0;
          if (i_rx_data[15:8] != MAGIC) begin
            // Target field of a non-frame word is meaningless; report 0.
            status_d = {1'b0, CODE_MAGIC, 2'b00, 10'd0};
            state_d  = S_REPORT;
          end else if (i_rx_data[1:0] == 2'd3) begin
            status_d = {1'b0, CODE_TGT, i_rx_data[1:0], 10'd0};
            state_d  = S_REPORT;
          end else begin
            target_d = i_rx_data[1:0];
            state_d  = S_ADDR;
          end
        end
      end

      S_ADDR: begin
        if (accept) begin
          waddr_d = i_rx_data[ADDR_WIDTH-1:0];
          range_d = |i_rx_data[DATA_WIDTH-1:ADDR_WIDTH];
          state_d = S_LEN;
        end
      end

      S_LEN: begin
        if (accept) begin
          if (i_rx_data == '0) begin
            status_d = {1'b0, CODE_LEN0, target_q, 10'd0};
            state_d  = S_REPORT;
          end else begin
            remain_d = i_rx_data;
            range_d  = range_q || (end_ext > MEM_DEPTH);
            state_d  = S_PAY;
          end
        end
      end

      S_PAY: begin
        if (accept) begin
          sum_d    = sum_q + i_rx_data;
          remain_d = remain_q - 16'd1;
          // An out-of-range frame is still consumed so the stream stays aligned.
          if (!range_q) begin
            mem_we_d    = 1'b1;
            mem_sel_d   = target_q;
            mem_addr_d  = waddr_q;
            mem_wdata_d = i_rx_data;
            waddr_d     = waddr_q + 1'b1;
            written_d   = written_q + 10'd1;
          end
          if (remain_q == 16'd1) begin
            state_d = S_CSUM;
          end
        end
      end

      S_CSUM: begin
        if (accept) begin
          if (range_q) begin
            status_d = {1'b0, CODE_RANGE, target_q, 10'd0};
          end else if (i_rx_data != sum_q) begin
            status_d = {1'b0, CODE_CSUM, target_q, written_q};
          end else begin
            status_d = {1'b1, CODE_OK, target_q, written_q};
          end
          state_d = S_REPORT;
        end
      end

      S_REPORT: begin
        if (i_status_ready) begin
          state_d = S_HDR;
        end
      end

      default: begin
        state_d = S_HDR;
      end
    endcase
  end

  always_ff @(posedge i_usb_ifclk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_HDR;
      target_q    <= '0;
      waddr_q     <= '0;
      remain_q    <= '0;
      sum_q       <= '0;
      range_q     <= 1'b0;
      written_q   <= '0;
      status_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_sel_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      waddr_q     <= waddr_d;
      remain_q    <= remain_d;
      sum_q       <= sum_d;
      range_q     <= range_d;
      written_q   <= written_d;
      status_q    <= status_d;
      mem_we_q    <= mem_we_d;
      mem_sel_q   <= mem_sel_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_usb_frame_parser.sv
module tb_usb_frame_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [15:0] rx_data = '0;
  logic        rx_ready;
  logic        mem_we;
  logic [1:0]  mem_sel;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        status_valid;
  logic [15:0] status;
  logic        status_ready = 1'b1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [9:0]  wr_addr[$];
  logic [15:0] wr_data[$];
  logic [1:0]  wr_sel[$];
  int          wr_cyc[$];
  logic [15:0] st_log[$];
  logic [15:0] seq[$];

  usb_frame_parser #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) dut (
    .i_usb_ifclk    (clk),
    .i_rst          (rst),
    .i_rx_valid     (rx_valid),
    .i_rx_data      (rx_data),
    .o_rx_ready     (rx_ready),
    .o_mem_we       (mem_we),
    .o_mem_sel      (mem_sel),
    .o_mem_addr     (mem_addr),
    .o_mem_wdata    (mem_wdata),
    .o_status_valid (status_valid),
    .o_status       (status),
    .i_status_ready (status_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change at posedge+1, so the negedge sees stable values.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      wr_sel.push_back(mem_sel);
      wr_cyc.push_back(cyc);
    end
    if (status_valid && status_ready && !rst) st_log.push_back(status);
  end

  task automatic clear_logs();
    wr_addr.delete(); wr_data.delete(); wr_sel.delete(); wr_cyc.delete(); st_log.delete();
  endtask

  // Present a word; returns once the next posedge will transfer it.
  task automatic send(input logic [15:0] w);
    int n = 0;
    logic ok = 1'b0;
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = w;
    do begin
      @(negedge clk);
      ok = rx_ready;
      n++;
    end while (!ok && n < 100);
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_timeout word=%h rx_ready stuck at 0, required 1", w);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [15:0] ws[$]);
    foreach (ws[i]) send(ws[i]);
    idle();
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    settle(2);
    checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL rst_rx_ready got %b exp 1", rx_ready); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got %b exp 0", mem_we); end
    checks++; if ({mem_sel, mem_addr, mem_wdata} !== 28'h0) begin failures++; $display("FAIL rst_mem_bus got %h exp 0", {mem_sel, mem_addr, mem_wdata}); end
    checks++; if (status_valid !== 1'b0) begin failures++; $display("FAIL rst_status_valid got %b exp 0", status_valid); end
    checks++; if (status !== 16'h0000) begin failures++; $display("FAIL rst_status got %h exp 0000", status); end
    @(posedge clk); #1 rst = 1'b0;
    settle(2);
  endtask

  task automatic test_image();
    logic [9:0]  ea[3] = '{10'h010, 10'h011, 10'h012};
    logic [15:0] ed[3] = '{16'h1111, 16'h2222, 16'h3333};
    clear_logs();
    seq = '{16'hA500, 16'h0010, 16'h0003, 16'h1111, 16'h2222, 16'h3333, 16'h6666};
    send_seq(seq);
    settle(4);
    checks++; if (wr_addr.size() != 3) begin failures++; $display("FAIL image_nwrites got %0d exp 3", wr_addr.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wr_addr[i] !== ea[i] || wr_data[i] !== ed[i] || wr_sel[i] !== 2'd0) begin
          failures++;
          $display("FAIL image_write%0d got a=%h d=%h s=%0d exp a=%h d=%h s=0", i, wr_addr[i], wr_data[i], wr_sel[i], ea[i], ed[i]);
        end
      end
      checks++; if (wr_cyc[1] != wr_cyc[0] + 1 || wr_cyc[2] != wr_cyc[1] + 1) begin
        failures++; $display("FAIL image_back_to_back got cycles %0d %0d %0d exp consecutive", wr_cyc[0], wr_cyc[1], wr_cyc[2]);
      end
    end
    checks++; if (st_log.size() != 1 || st_log[0] !== 16'h8003) begin
      failures++; $display("FAIL image_status got n=%0d s=%h exp n=1 s=8003", st_log.size(), (st_log.size() > 0) ? st_log[0] : 16'hxxxx);
    end
  endtask

  task automatic test_bad_magic();
    clear_logs();
    seq = '{16'h5A01, 16'hA501, 16'h0020, 16'h0001, 16'h00AB, 16'h00AB};
    send_seq(seq);
    settle(4);
    checks++; if (st_log.size() != 2) begin failures++; $display("FAIL magic_nstatus got %0d exp 2", st_log.size()); end
    else begin
      checks++; if (st_log[0] !== 16'h1000) begin failures++; $display("FAIL magic_status got %h exp 1000", st_log[0]); end
      checks++; if (st_log[1] !== 16'h8401) begin failures++; $display("FAIL magic_next_status got %h exp 8401", st_log[1]); end
    end
    checks++; if (wr_addr.size() != 1) begin failures++; $display("FAIL magic_nwrites got %0d exp 1", wr_addr.size()); end
    else begin
      checks++; if (wr_addr[0] !== 10'h020 || wr_data[0] !== 16'h00AB || wr_sel[0] !== 2'd1) begin
        failures++; $display("FAIL magic_next_write got a=%h d=%h s=%0d exp a=020 d=00ab s=1", wr_addr[0], wr_data[0], wr_sel[0]);
      end
    end
  endtask

  task automatic test_range();
    clear_logs();
    seq = '{16'hA502, 16'h03FE, 16'h0004, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h000A};
    send_seq(seq);
    // Upper address bits set: out of range even though one word would fit.
    seq = '{16'hA500, 16'h0400, 16'h0001, 16'h0005, 16'h0005};
    send_seq(seq);
    // Exactly filling the last word of memory is in range.
    seq = '{16'hA501, 16'h03FF, 16'h0001, 16'h0009, 16'h0009};
    send_seq(seq);
    settle(4);
    checks++; if (wr_addr.size() != 1 || wr_addr[0] !== 10'h3FF || wr_sel[0] !== 2'd1) begin
      failures++; $display("FAIL range_writes got n=%0d exp n=1 at 3ff sel 1", wr_addr.size());
    end
    checks++; if (st_log.size() != 3) begin failures++; $display("FAIL range_nstatus got %0d exp 3", st_log.size()); end
    else begin
      checks++; if (st_log[0] !== 16'h4800) begin failures++; $display("FAIL range_overflow got %h exp 4800", st_log[0]); end
      checks++; if (st_log[1] !== 16'h4000) begin failures++; $display("FAIL range_upper_bits got %h exp 4000", st_log[1]); end
      checks++; if (st_log[2] !== 16'h8401) begin failures++; $display("FAIL range_edge got %h exp 8401", st_log[2]); end
    end
  endtask

  task automatic test_csum_err();
    clear_logs();
    seq = '{16'hA500, 16'h0000, 16'h0002, 16'h0001, 16'h0002, 16'h0004};
    send_seq(seq);
    settle(4);
    checks++; if (wr_addr.size() != 2) begin failures++; $display("FAIL csum_nwrites got %0d exp 2", wr_addr.size()); end
    else begin
      checks++; if (wr_addr[0] !== 10'h000 || wr_addr[1] !== 10'h001 || wr_data[1] !== 16'h0002) begin
        failures++; $display("FAIL csum_writes got a0=%h a1=%h d1=%h exp 000 001 0002", wr_addr[0], wr_addr[1], wr_data[1]);
      end
    end
    checks++; if (st_log.size() != 1 || st_log[0] !== 16'h5002) begin
      failures++; $display("FAIL csum_status got n=%0d s=%h exp n=1 s=5002", st_log.size(), (st_log.size() > 0) ? st_log[0] : 16'hxxxx);
    end
  endtask

  task automatic test_short_errors();
    clear_logs();
    seq = '{16'hA503};
    send_seq(seq);
    seq = '{16'hA501, 16'h0000, 16'h0000};
    send_seq(seq);
    settle(4);
    checks++; if (st_log.size() != 2 || st_log[0] !== 16'h2C00 || st_log[1] !== 16'h3400) begin
      failures++; $display("FAIL short_errors got n=%0d exp 2C00 then 3400", st_log.size());
    end
    checks++; if (wr_addr.size() != 0) begin failures++; $display("FAIL short_errors_writes got %0d exp 0", wr_addr.size()); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    int bad = 0;
    clear_logs();
    @(posedge clk); #1 status_ready = 1'b0;
    seq = '{16'hA500, 16'h0005, 16'h0001, 16'h1234};
    foreach (seq[i]) send(seq[i]);
    send(16'h1234);
    @(posedge clk); #1;
    rx_data = 16'hA501;  // next header offered while status is pending
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rx_ready !== 1'b0 || status_valid !== 1'b1 || status !== 16'h8001) bad++;
    end
    checks++; if (bad != 0) begin
      failures++; $display("FAIL backpressure_hold got %0d bad cycles (rdy=%b v=%b s=%h) exp 0", bad, rx_ready, status_valid, status);
    end
    @(posedge clk); #1 status_ready = 1'b1;
    do begin @(negedge clk); n++; end while (!rx_ready && n < 20);
    checks++; if (!rx_ready) begin failures++; $display("FAIL backpressure_release rx_ready got 0 exp 1"); end
    seq = '{16'h0030, 16'h0001, 16'h0007, 16'h0007};
    send_seq(seq);
    settle(4);
    checks++; if (st_log.size() != 2 || st_log[0] !== 16'h8001 || st_log[1] !== 16'h8401) begin
      failures++; $display("FAIL backpressure_status got n=%0d exp 8001 then 8401", st_log.size());
    end
    checks++; if (wr_addr.size() != 2 || wr_addr[1] !== 10'h030 || wr_sel[1] !== 2'd1 || wr_data[1] !== 16'h0007) begin
      failures++; $display("FAIL backpressure_writes got n=%0d exp 2 with last at 030 sel 1 data 0007", wr_addr.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    seq = '{16'hA500, 16'h0040, 16'h0004, 16'h0101, 16'h0202};
    foreach (seq[i]) send(seq[i]);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL midrst_pending_we got %b exp 1", mem_we); end
    #1 rst = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0 || mem_addr !== 10'h0 || mem_wdata !== 16'h0 || mem_sel !== 2'd0) begin
      failures++; $display("FAIL midrst_async got we=%b a=%h d=%h s=%0d exp all 0", mem_we, mem_addr, mem_wdata, mem_sel);
    end
    checks++; if (rx_ready !== 1'b1 || status_valid !== 1'b0 || status !== 16'h0) begin
      failures++; $display("FAIL midrst_state got rdy=%b v=%b s=%h exp 1 0 0000", rx_ready, status_valid, status);
    end
    @(posedge clk); #1 rst = 1'b0;
    settle(5);
    checks++; if (st_log.size() != 0 || wr_addr.size() != 1) begin
      failures++; $display("FAIL midrst_discard got status=%0d writes=%0d exp 0 and 1", st_log.size(), wr_addr.size());
    end
    seq = '{16'hA500, 16'h0100, 16'h0001, 16'h0055, 16'h0055};
    send_seq(seq);
    settle(4);
    checks++; if (st_log.size() != 1 || st_log[0] !== 16'h8001) begin
      failures++; $display("FAIL midrst_next_status got n=%0d s=%h exp 8001", st_log.size(), (st_log.size() > 0) ? st_log[0] : 16'hxxxx);
    end
    checks++; if (wr_addr.size() != 2 || wr_addr[1] !== 10'h100) begin
      failures++; $display("FAIL midrst_next_write got n=%0d exp 2 with last at 100", wr_addr.size());
    end
  endtask

  initial begin
    test_reset();
    test_image();
    test_bad_magic();
    test_range();
    test_csum_err();
    test_short_errors();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation time exceeded limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/usb_frame_parser.md
# usb_frame_parser

Receive-side command parser that sits directly behind the USB EP2 read path. It consumes the 16-bit word stream drained from the FX2 FIFO, decodes framed load commands, and writes their payloads into the CNN's image, weight or bias memory. After each frame it hands a one-word status to the EP6 write path for return to the host.

## Interface
Parameters:
- DATA_WIDTH, 16, USB word width; the frame format is defined only for 16.
- ADDR_WIDTH, 10, width of the target-memory word address; the memory depth is 2^ADDR_WIDTH.

Ports:
- i_usb_ifclk  in  1  sole clock; the USB interface clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_rx_valid  in  1  i_rx_data holds a received word.
- i_rx_data  in  DATA_WIDTH  received word.
- o_rx_ready  out  1  parser can accept a word. A word transfers when i_rx_valid and o_rx_ready are both 1.
- o_mem_we  out  1  write strobe, one cycle per payload word.
- o_mem_sel  out  2  target memory: 0 image, 1 weight, 2 bias.
- o_mem_addr  out  ADDR_WIDTH  write address.
- o_mem_wdata  out  DATA_WIDTH  write data.
- o_status_valid  out  1  status word pending.
- o_status  out  16  status word; bit 15 ok, bits 14:12 error code, bits 11:10 target, bits 9:0 = words written mod 1024.
- i_status_ready  in  1  TX path accepts the status; the transfer occurs when this and o_status_valid are both 1.

## Operation
- Frame layout, in order:
  - H: {8'hA5, 6'b0, target[1:0]}
  - A: start address; the low ADDR_WIDTH bits are used and the upper bits must be 0.
  - L: payload length N, range 1..65535.
  - N payload words.
  - C: checksum, the 16-bit sum mod 2^16 of the payload words.
- States:
  - S_HDR: wait for H.
  - S_ADDR: wait for A.
  - S_LEN: wait for L.
  - S_PAY: consume payload words.
  - S_CSUM: wait for C.
  - S_REPORT: present status.
- Transitions and error codes (only an accepted word advances the state):
  - S_HDR: if H[15:8] != 8'hA5, report code 1 and write nothing. Otherwise, if target == 3, report code 2. Otherwise go to S_ADDR.
  - S_ADDR: go to S_LEN. Latch the base address; set a range flag if A[15:ADDR_WIDTH] != 0.
  - S_LEN: if N == 0, report code 3. Otherwise go to S_PAY. Also set the range flag if base + N > 2^ADDR_WIDTH; evaluate this at ADDR_WIDTH+17 bits with no wrap.
  - S_PAY: for each word, add it to the checksum and decrement the remaining count. Write the word to base + index only if the range flag is clear. After the N-th word go to S_CSUM.
  - S_CSUM: if the range flag is set, report code 4. Otherwise, if C != the computed sum, report code 5. Otherwise report ok with code 0.
  - S_REPORT: hold o_status_valid until the handshake, then return to S_HDR.
- Code 4 takes priority over code 5.
- Words already written are not rolled back on a checksum error.
- The word count in o_status is the number of words actually written, so it is 0 for codes 1–4.
- Frames may span multiple USB packets. The parser has no timeout.

## Timing
- o_rx_ready = 1 in every state except S_REPORT, decoded from the state register.
- The memory write is registered. o_mem_we/addr/wdata are valid in the cycle after the payload word is accepted, and o_mem_we is high for exactly one cycle per word.
- Back-to-back payload words produce back-to-back writes with consecutive addresses.
- o_status_valid rises in the cycle after the word that ends the frame is accepted: H for codes 1/2, L for code 3, C for the others.
- o_status is stable while o_status_valid = 1.
- If i_status_ready is already high, the handshake completes in that first cycle. o_rx_ready returns to 1 in the following cycle.
- There is no lost word: upstream holds i_rx_valid/i_rx_data while o_rx_ready = 0.
- Reset values: state S_HDR, o_rx_ready 1, o_mem_we 0, o_mem_sel 0, o_mem_addr 0, o_mem_wdata 0, o_status_valid 0, o_status 0, and checksum, count and range flag all cleared.
- Reset mid-frame: the partial frame is discarded, no status is emitted, and parsing restarts at S_HDR.
- Reset while a write strobe is pending clears o_mem_we immediately.

## Test plan
- Valid image frame: A5_00, 0010, 0003, 1111, 2222, 3333, 6666 -> three one-cycle writes, sel 0, addr 0x010/0x011/0x012, data 1111/2222/3333; then status 0x8003.
- Bad magic 5A_01 followed by a valid weight frame -> status 0x1000 with no writes; the next frame parses normally and reports sel 1 (bits 11:10 = 01).
- Range overflow: A5_02, 03FE, 0004, four payload words, correct checksum -> no writes, status 0x4800 (code 4, target 2, count 0).
- Checksum error: A5_00, 0000, 0002, 0001, 0002, 0004 -> two writes occur, then status 0x5002.
- Status backpressure: hold i_status_ready = 0 for 10 cycles after a valid frame while upstream offers H of the next frame -> o_rx_ready = 0 and o_status is constant for all 10 cycles; after the handshake the held H is accepted once.
- Reset mid-frame: assert i_rst after the second of four payload words -> all outputs reach their reset values asynchronously and no status is emitted; a following clean frame reports ok.
